// File: rtl/uart_ctl.sv
// rtl/uart_ctl.sv - parametrised full-duplex UART controller with TX/RX FIFOs
//
// Optional feature macro: UART_PARITY_EN (one parity bit after data, checked on RX)
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   uart_rx        asynchronous serial input, idle high
//   uart_tx        registered serial output, idle high
//   tx_data/tx_valid/tx_ready   TX stream into the TX FIFO
//   rx_data/rx_valid/rx_ready   RX stream out of the RX FIFO (first-word fall-through)
//   tx_busy        frame on the line or TX FIFO non-empty
//   rx_frame_err   one-cycle pulse, stop bit sampled low
//   rx_parity_err  one-cycle pulse, parity mismatch (0 without UART_PARITY_EN)
//   rx_overrun     one-cycle pulse, received byte dropped because RX FIFO full

// First-word fall-through FIFO; ready/valid come from the registered count.
module uart_ctl_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] inData,
   input  logic             inValid,
   output logic             inReady,
   output logic [WIDTH-1:0] outData,
   output logic             outValid,
   input  logic             outReady
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic [AW:0]      count;
   logic             doPush;
   logic             doPop;

   assign inReady  = (count != FULL_CNT);
   assign outValid = (count != '0);
   assign doPush   = inValid && inReady;
   assign doPop    = outValid && outReady;
   // Empty FIFO presents zero so the consumer never sees stale storage.
   assign outData  = outValid ? mem[rdPtr] : '0;

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= inData;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + AW'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + AW'(1);
         end
         case ({doPush, doPop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module uart_ctl #(
   parameter int CLKS_PER_BIT = 234,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 uart_rx,
   output logic                 uart_tx,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 tx_busy,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun
);
`ifdef UART_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam bit PAR_ODD = (PARITY_ODD != 0);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rxState_t;

   // ---------------- TX ----------------
   txState_t             txState, txStateNxt;
   logic [CW-1:0]        txCnt, txCntNxt;
   logic [2:0]           txIdx, txIdxNxt;
   logic [DATA_BITS-1:0] txShift, txShiftNxt;
   logic                 txPar, txParNxt;
   logic                 txBit;
   logic                 txLoad;
   logic                 txPop;
   logic                 txLine;
   logic                 txLineBusy;
   logic [DATA_BITS-1:0] txHead;
   logic                 txHeadValid;
   logic                 txBitEnd;

   uart_ctl_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) txFifo (
      .clk      (clk),
      .rst      (rst),
      .inData   (tx_data),
      .inValid  (tx_valid),
      .inReady  (tx_ready),
      .outData  (txHead),
      .outValid (txHeadValid),
      .outReady (txPop)
   );

   assign txBitEnd = (txCnt == BIT_LAST);

   always_comb begin
      txStateNxt = txState;
      txCntNxt   = txBitEnd ? '0 : txCnt + CW'(1);
      txIdxNxt   = txIdx;
      txShiftNxt = txShift;
      txParNxt   = txPar;
      txBit      = 1'b1;
      txLoad     = 1'b0;
      txPop      = 1'b0;
      case (txState)
         TX_IDLE: begin
            txCntNxt = '0;
            txLoad   = txHeadValid;
         end
         TX_START: begin
            txBit = 1'b0;
            if (txBitEnd) begin
               txStateNxt = TX_DATA;
               txIdxNxt   = '0;
            end
         end
         TX_DATA: begin
            txBit = txShift[0];
            if (txBitEnd) begin
               txShiftNxt = {1'b0, txShift[DATA_BITS-1:1]};
               if (txIdx == DATA_LAST) begin
                  txIdxNxt   = '0;
                  txStateNxt = PAR_EN ? TX_PARITY : TX_STOP;
               end else begin
                  txIdxNxt = txIdx + 3'd1;
               end
            end
         end
         TX_PARITY: begin
            txBit = txPar;
            if (txBitEnd) begin
               txStateNxt = TX_STOP;
               txIdxNxt   = '0;
            end
         end
         TX_STOP: begin
            txBit = 1'b1;
            if (txBitEnd) begin
               if (txIdx == STOP_LAST) begin
                  txIdxNxt   = '0;
                  txStateNxt = TX_IDLE;
                  // Chain straight into the next start bit so frames abut.
                  txLoad     = txHeadValid;
               end else begin
                  txIdxNxt = txIdx + 3'd1;
               end
            end
         end
         default: txStateNxt = TX_IDLE;
      endcase
      if (txLoad) begin
         txPop      = 1'b1;
         txShiftNxt = txHead;
         txParNxt   = (^txHead) ^ PAR_ODD;
         txStateNxt = TX_START;
         txCntNxt   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         txState    <= TX_IDLE;
         txCnt      <= '0;
         txIdx      <= '0;
         txShift    <= '0;
         txPar      <= 1'b0;
         txLine     <= 1'b1;
         txLineBusy <= 1'b0;
      end else begin
         txState    <= txStateNxt;
         txCnt      <= txCntNxt;
         txIdx      <= txIdxNxt;
         txShift    <= txShiftNxt;
         txPar      <= txParNxt;
         // The line lags the FSM by one cycle; txLineBusy tracks that lag
         // so tx_busy covers the final stop bit as it appears on the pin.
         txLine     <= txBit;
         txLineBusy <= (txState != TX_IDLE);
      end
   end

   assign uart_tx = txLine;
   assign tx_busy = txHeadValid || (txState != TX_IDLE) || txLineBusy;

   // ---------------- RX ----------------
   rxState_t             rxState, rxStateNxt;
   logic [CW-1:0]        rxCnt, rxCntNxt;
   logic [2:0]           rxIdx, rxIdxNxt;
   logic [DATA_BITS-1:0] rxShift, rxShiftNxt;
   logic                 rxParBit, rxParBitNxt;
   logic                 rxMeta, rxSync;
   logic                 rxPush;
   logic                 rxFifoReady;
   logic                 rxParBad;
   logic                 frameErrNxt, parErrNxt, overrunNxt;
   logic                 frameErrQ, parErrQ, overrunQ;

   uart_ctl_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) rxFifo (
      .clk      (clk),
      .rst      (rst),
      .inData   (rxShift),
      .inValid  (rxPush),
      .inReady  (rxFifoReady),
      .outData  (rx_data),
      .outValid (rx_valid),
      .outReady (rx_ready)
   );

   assign rxParBad = PAR_EN && (rxParBit != ((^rxShift) ^ PAR_ODD));

   always_comb begin
      rxStateNxt  = rxState;
      rxCntNxt    = rxCnt + CW'(1);
      rxIdxNxt    = rxIdx;
      rxShiftNxt  = rxShift;
      rxParBitNxt = rxParBit;
      rxPush      = 1'b0;
      frameErrNxt = 1'b0;
      parErrNxt   = 1'b0;
      overrunNxt  = 1'b0;
      case (rxState)
         RX_IDLE: begin
            rxCntNxt = '0;
            if (!rxSync) begin
               rxStateNxt = RX_START;
            end
         end
         RX_START: begin
            // Half a bit in: still low means a real start bit, and from here
            // every sample lands one full bit later at the bit centre.
            if (rxCnt == HALF_LAST) begin
               rxCntNxt   = '0;
               rxIdxNxt   = '0;
               rxStateNxt = rxSync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rxCnt == BIT_LAST) begin
               rxCntNxt   = '0;
               rxShiftNxt = {rxSync, rxShift[DATA_BITS-1:1]};
               if (rxIdx == DATA_LAST) begin
                  rxIdxNxt   = '0;
                  rxStateNxt = PAR_EN ? RX_PARITY : RX_STOP;
               end else begin
                  rxIdxNxt = rxIdx + 3'd1;
               end
            end
         end
         RX_PARITY: begin
            if (rxCnt == BIT_LAST) begin
               rxCntNxt    = '0;
               rxParBitNxt = rxSync;
               rxStateNxt  = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rxCnt == BIT_LAST) begin
               rxCntNxt = '0;
               if (!rxSync) begin
                  frameErrNxt = 1'b1;
                  rxStateNxt  = RX_WAIT_HIGH;
               end else begin
                  rxStateNxt = RX_IDLE;
                  if (rxParBad) begin
                     parErrNxt = 1'b1;
                  end else if (rxFifoReady) begin
                     rxPush = 1'b1;
                  end else begin
                     overrunNxt = 1'b1;
                  end
               end
            end
         end
         RX_WAIT_HIGH: begin
            // A held-low line (break) must not be mistaken for a new start bit.
            rxCntNxt = '0;
            if (rxSync) begin
               rxStateNxt = RX_IDLE;
            end
         end
         default: rxStateNxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rxMeta    <= 1'b1;
         rxSync    <= 1'b1;
         rxState   <= RX_IDLE;
         rxCnt     <= '0;
         rxIdx     <= '0;
         rxShift   <= '0;
         rxParBit  <= 1'b0;
         frameErrQ <= 1'b0;
         parErrQ   <= 1'b0;
         overrunQ  <= 1'b0;
      end else begin
         rxMeta    <= uart_rx;
         rxSync    <= rxMeta;
         rxState   <= rxStateNxt;
         rxCnt     <= rxCntNxt;
         rxIdx     <= rxIdxNxt;
         rxShift   <= rxShiftNxt;
         rxParBit  <= rxParBitNxt;
         frameErrQ <= frameErrNxt;
         parErrQ   <= parErrNxt;
         overrunQ  <= overrunNxt;
      end
   end

   assign rx_frame_err  = frameErrQ;
   assign rx_parity_err = parErrQ;
   assign rx_overrun    = overrunQ;
endmodule

// File: tb/tb_uart_ctl.sv
// tb/tb_uart_ctl.sv - self-checking bench for uart_ctl
module tb_uart_ctl;
   localparam int CPB = 16;
   localparam int DW  = 8;
`ifdef UART_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NBITS = 1 + DW + PB + 1;
   localparam int FRAME = NBITS * CPB;

   logic          clk = 1'b0;
   logic          rst;
   logic          rxLine;
   logic          uart_tx;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          tx_busy;
   logic          rx_frame_err;
   logic          rx_parity_err;
   logic          rx_overrun;
   logic          loopEn;
   logic          rxDrive;

   logic [7:0] txExp[$];
   logic [7:0] rxExp[$];
   int errors = 0;
   int checks = 0;
   int feCnt = 0, peCnt = 0, ovCnt = 0, wideCnt = 0;
   logic prevFe = 1'b0, prevPe = 1'b0, prevOv = 1'b0;

   always #5 clk = ~clk;

   assign rxLine = loopEn ? uart_tx : rxDrive;

   uart_ctl #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DW),
      .STOP_BITS    (1),
      .FIFO_DEPTH   (4),
      .PARITY_ODD   (0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .uart_rx       (rxLine),
      .uart_tx       (uart_tx),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .tx_busy       (tx_busy),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err),
      .rx_overrun    (rx_overrun)
   );

   // Pulse counters; a pulse seen on two consecutive samples counts as too wide.
   always @(negedge clk) begin
      if (rx_frame_err === 1'b1)  feCnt <= feCnt + 1;
      if (rx_parity_err === 1'b1) peCnt <= peCnt + 1;
      if (rx_overrun === 1'b1)    ovCnt <= ovCnt + 1;
      if ((rx_frame_err && prevFe) || (rx_parity_err && prevPe) || (rx_overrun && prevOv))
         wideCnt <= wideCnt + 1;
      prevFe <= rx_frame_err;
      prevPe <= rx_parity_err;
      prevOv <= rx_overrun;
   end

   task automatic pushTx(input logic [7:0] d, input bit toRx);
      bit done = 1'b0;
      tx_data  = d;
      tx_valid = 1'b1;
      for (int i = 0; i < 400 && !done; i++) begin
         if (tx_ready === 1'b1) begin
            done = 1'b1;
            if (toRx) rxExp.push_back(d);
            else txExp.push_back(d);
         end
         @(negedge clk);
      end
      tx_valid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL push_timeout: tx_ready got 0 for 400 cycles, required 1");
      end
   endtask

   task automatic waitStart(input int budget, input string name);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (uart_tx === 1'b0) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s_start: no start bit within %0d cycles (uart_tx=%b), required 0", name, budget, uart_tx);
      end
   endtask

   // Called on the first sample of a start bit; returns on the last sample of the stop bit.
   task automatic sampleFrame(input string name);
      logic [7:0] exp;
      logic [7:0] d;
      logic       b;
      bit         stable;
      exp = (txExp.size() > 0) ? txExp.pop_front() : 8'hxx;
      d   = '0;
      for (int k = 0; k < NBITS; k++) begin
         b = uart_tx;
         stable = 1'b1;
         for (int c = 1; c < CPB; c++) begin
            @(negedge clk);
            if (uart_tx !== b) stable = 1'b0;
         end
         checks++;
         if (!stable) begin
            errors++;
            $display("FAIL %s_bit%0d_width: got change inside bit, required %0d stable cycles", name, k, CPB);
         end
         if (k == 0) begin
            checks++;
            if (b !== 1'b0) begin errors++; $display("FAIL %s_startbit: got %b required 0", name, b); end
         end else if (k <= DW) begin
            d[k-1] = b;
         end else if (k == NBITS - 1) begin
            checks++;
            if (b !== 1'b1) begin errors++; $display("FAIL %s_stopbit: got %b required 1", name, b); end
         end else begin
            checks++;
            if (b !== ^exp) begin errors++; $display("FAIL %s_paritybit: got %b required %b", name, b, ^exp); end
         end
         if (k < NBITS - 1) @(negedge clk);
      end
      checks++;
      if (d !== exp) begin errors++; $display("FAIL %s_data: got %02h required %02h", name, d, exp); end
   endtask

   task automatic sendRxFrame(input logic [7:0] d, input logic stopV, input logic parV);
      rxDrive = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < DW; i++) begin
         rxDrive = d[i];
         repeat (CPB) @(negedge clk);
      end
      if (PB != 0) begin
         rxDrive = parV;
         repeat (CPB) @(negedge clk);
      end
      rxDrive = stopV;
      repeat (CPB) @(negedge clk);
      rxDrive = 1'b1;
   endtask

   task automatic popRx(input int n, input int budget, input string name);
      int got = 0;
      logic [7:0] exp;
      rx_ready = 1'b1;
      for (int i = 0; i < budget && got < n; i++) begin
         if (rx_valid === 1'b1) begin
            exp = (rxExp.size() > 0) ? rxExp.pop_front() : 8'hxx;
            checks++;
            if (rx_data !== exp) begin errors++; $display("FAIL %s_data: got %02h required %02h", name, rx_data, exp); end
            got++;
         end
         @(negedge clk);
      end
      rx_ready = 1'b0;
      checks++;
      if (got != n) begin errors++; $display("FAIL %s_count: got %0d bytes required %0d", name, got, n); end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (uart_tx !== 1'b1)  begin errors++; $display("FAIL reset_uart_tx: got %b required 1", uart_tx); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %02h required 00", rx_data); end
      checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL reset_tx_busy: got %b required 0", tx_busy); end
      checks++;
      if ({rx_frame_err, rx_parity_err, rx_overrun} !== 3'b000) begin
         errors++; $display("FAIL reset_err_pulses: got %b required 000", {rx_frame_err, rx_parity_err, rx_overrun});
      end
   endtask

   task automatic test_single_tx;
      pushTx(8'hA5, 1'b0);
      checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b required 1", tx_busy); end
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_latency_n1: got %b required 1", uart_tx); end
      @(negedge clk);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_latency_n2: got %b required 1", uart_tx); end
      waitStart(1, "single");
      sampleFrame("single");
      checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_stop: got %b required 1", tx_busy); end
      @(negedge clk);
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b required 0", tx_busy); end
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_idle_line: got %b required 1", uart_tx); end
   endtask

   task automatic test_back_to_back;
      fork
         begin
            for (int i = 1; i <= 5; i++) pushTx(8'(i), 1'b0);
            checks++;
            if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b required 0", tx_ready); end
         end
         begin
            waitStart(40, "b2b0");
            sampleFrame("b2b0");
            for (int f = 1; f < 5; f++) begin
               waitStart(1, "b2b_gap");
               sampleFrame("b2b");
            end
         end
      join
      repeat (2) @(negedge clk);
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b required 0", tx_busy); end
   endtask

   task automatic test_loopback;
      int fe0 = feCnt, pe0 = peCnt, ov0 = ovCnt, w0 = wideCnt;
      loopEn = 1'b1;
      pushTx(8'h00, 1'b1);
      pushTx(8'hFF, 1'b1);
      pushTx(8'h5A, 1'b1);
      popRx(3, 4 * FRAME, "loop");
      repeat (2 * CPB) @(negedge clk);
      loopEn = 1'b0;
      checks++;
      if ((feCnt - fe0) + (peCnt - pe0) + (ovCnt - ov0) + (wideCnt - w0) != 0) begin
         errors++;
         $display("FAIL loop_err_pulses: got fe=%0d pe=%0d ov=%0d required 0", feCnt - fe0, peCnt - pe0, ovCnt - ov0);
      end
   endtask

   task automatic test_glitch_frame_err;
      int fe0 = feCnt, w0 = wideCnt;
      rxDrive = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rxDrive = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_rx_valid: got %b required 0", rx_valid); end
      checks++; if (feCnt != fe0) begin errors++; $display("FAIL glitch_frame_err: got %0d pulses required 0", feCnt - fe0); end
      sendRxFrame(8'h96, 1'b0, ^8'h96);
      repeat (CPB) @(negedge clk);
      checks++; if (feCnt - fe0 != 1) begin errors++; $display("FAIL frame_err_pulse: got %0d pulses required 1", feCnt - fe0); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL frame_err_fifo: got rx_valid=%b required 0", rx_valid); end
      checks++; if (wideCnt != w0) begin errors++; $display("FAIL frame_err_width: got %0d wide pulses required 0", wideCnt - w0); end
      rxExp.push_back(8'h3C);
      sendRxFrame(8'h3C, 1'b1, ^8'h3C);
      popRx(1, 4 * CPB, "recover");
   endtask

   task automatic test_overrun;
      logic [7:0] bytes [5];
      int ov0 = ovCnt, fe0 = feCnt, w0 = wideCnt;
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      rx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) rxExp.push_back(bytes[i]);
         sendRxFrame(bytes[i], 1'b1, ^bytes[i]);
      end
      repeat (CPB) @(negedge clk);
      checks++; if (ovCnt - ov0 != 1) begin errors++; $display("FAIL overrun_pulse: got %0d pulses required 1", ovCnt - ov0); end
      checks++; if (wideCnt != w0) begin errors++; $display("FAIL overrun_width: got %0d wide pulses required 0", wideCnt - w0); end
      checks++; if (feCnt != fe0) begin errors++; $display("FAIL overrun_frame_err: got %0d pulses required 0", feCnt - fe0); end
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_rx_valid: got %b required 1", rx_valid); end
      popRx(4, 40, "overrun");
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_drained: got rx_valid=%b required 0", rx_valid); end
   endtask

`ifdef UART_PARITY_EN
   task automatic test_parity;
      int pe0 = peCnt;
      sendRxFrame(8'h03, 1'b1, 1'b1);
      repeat (CPB) @(negedge clk);
      checks++; if (peCnt - pe0 != 1) begin errors++; $display("FAIL parity_err_pulse: got %0d pulses required 1", peCnt - pe0); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL parity_discard: got rx_valid=%b required 0", rx_valid); end
      rxExp.push_back(8'h03);
      sendRxFrame(8'h03, 1'b1, 1'b0);
      popRx(1, 4 * CPB, "parity_ok");
      checks++; if (peCnt - pe0 != 1) begin errors++; $display("FAIL parity_ok_pulse: got %0d pulses required 1", peCnt - pe0); end
   endtask
`endif

   task automatic test_reset_midframe;
      bit quiet = 1'b1;
      pushTx(8'h81, 1'b0);
      pushTx(8'h42, 1'b0);
      repeat (5 * CPB) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (uart_tx !== 1'b1)  begin errors++; $display("FAIL midrst_uart_tx: got %b required 1", uart_tx); end
      checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL midrst_tx_busy: got %b required 0", tx_busy); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_tx_ready: got %b required 1", tx_ready); end
      rst = 1'b0;
      txExp.delete();
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) quiet = 1'b0;
      end
      checks++; if (!quiet) begin errors++; $display("FAIL midrst_line_quiet: got activity required idle line"); end
   endtask

   initial begin
      rst      = 1'b1;
      tx_data  = '0;
      tx_valid = 1'b0;
      rx_ready = 1'b0;
      loopEn   = 1'b0;
      rxDrive  = 1'b1;
      test_reset;
      test_single_tx;
      test_back_to_back;
      test_loopback;
      test_glitch_frame_err;
      test_overrun;
`ifdef UART_PARITY_EN
      test_parity;
`endif
      test_reset_midframe;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
